neuron_row_mac: RTL and testbench

//  Parametrised neuron core: streams NUM_ROWS rows of ROW_LEN pixel/weight pairs, one row per accepted beat.

---
 rtl/neuron_pkg.sv | 23 ++
 rtl/row_dot_product.sv | 45 ++++
 rtl/neuron_row_mac.sv | 137 +++++++++++++
 tb/tb_neuron_row_mac.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared widths, state encoding and accumulator sizing for the neuron cores.
// Pure declarations; no logic, latency or flow control.
package neuron_pkg;

    localparam int PIX_W_D    = 10;
    localparam int WGT_W_D    = 19;
    localparam int ROW_LEN_D  = 28;
    localparam int NUM_ROWS_D = 28;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        BIAS  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Wide enough for every row's worth of products plus the bias, with no overflow.
    function automatic int acc_width(input int pix_w, input int wgt_w,
                                     input int row_len, input int num_rows);
        return pix_w + wgt_w + 2 + $clog2(row_len * num_rows);
    endfunction

endpackage

// File: rtl/row_dot_product.sv
// Signed dot product of one row: unsigned pixels times signed weights, balanced adder tree.
// Purely combinational (zero latency); no flow control.
module row_dot_product
    import neuron_pkg::*;
#(
    parameter int PIX_W   = PIX_W_D,
    parameter int WGT_W   = WGT_W_D,
    parameter int ROW_LEN = ROW_LEN_D,
    localparam int DOT_W  = PIX_W + WGT_W + 1 + $clog2(ROW_LEN)
) (
    input  logic [ROW_LEN*PIX_W-1:0] row_pix,
    input  logic [ROW_LEN*WGT_W-1:0] row_wgt,
    output logic signed [DOT_W-1:0]  dot
);

    localparam int PRD_W = PIX_W + WGT_W + 1;
    localparam int LVLS  = $clog2(ROW_LEN);
    localparam int NPAD  = 1 << LVLS;

    genvar l, i;
    for (l = 0; l <= LVLS; l++) begin : g_lvl
        logic signed [DOT_W-1:0] node [NPAD >> l];
        for (i = 0; i < (NPAD >> l); i++) begin : g_node
            if (l == 0) begin : g_leaf
                if (i < ROW_LEN) begin : g_mul
                    logic signed [PRD_W-1:0] pix_x;
                    logic signed [PRD_W-1:0] wgt_x;
                    logic signed [PRD_W-1:0] prod;
                    assign pix_x = PRD_W'({1'b0, row_pix[i*PIX_W +: PIX_W]});
                    assign wgt_x = PRD_W'($signed(row_wgt[i*WGT_W +: WGT_W]));
                    assign prod  = pix_x * wgt_x;
                    assign node[i] = DOT_W'(prod);
                end else begin : g_pad
                    // Padding leaves keep the tree balanced for non power-of-two rows.
                    assign node[i] = '0;
                end
            end else begin : g_add
                assign node[i] = g_lvl[l-1].node[2*i] + g_lvl[l-1].node[2*i+1];
            end
        end
    end

    assign dot = g_lvl[LVLS].node[0];

endmodule

// File: rtl/neuron_row_mac.sv
// Neuron core: accumulates NUM_ROWS row dot products plus Beta, emits step activation (NEURON_SCORE_OUT_EN adds Out_Score).
// Out_Valid 2 cycles after last accepted row; Row_Ready is a registered ACCUM decode, independent of Row_Valid.
module neuron_row_mac
    import neuron_pkg::*;
#(
    parameter int PIX_W    = PIX_W_D,
    parameter int WGT_W    = WGT_W_D,
    parameter int ROW_LEN  = ROW_LEN_D,
    parameter int NUM_ROWS = NUM_ROWS_D,
    localparam int ACC_W   = acc_width(PIX_W, WGT_W, ROW_LEN, NUM_ROWS)
) (
    input  logic                     clk,
    input  logic                     GlobalReset,
    input  logic                     Start,
    input  logic [WGT_W-1:0]         Beta,
    input  logic                     Row_Valid,
    output logic                     Row_Ready,
    input  logic [ROW_LEN*PIX_W-1:0] Row_Pixel,
    input  logic [ROW_LEN*WGT_W-1:0] Row_Weight,
    output logic                     Out_Valid,
    output logic                     Out_X
`ifdef NEURON_SCORE_OUT_EN
    ,
    output logic [ACC_W-1:0]         Out_Score
`endif
);

    localparam int DOT_W = PIX_W + WGT_W + 1 + $clog2(ROW_LEN);
    localparam int CNT_W = $clog2(NUM_ROWS);

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]          row_cnt_q, row_cnt_d;
    logic signed [WGT_W-1:0]   beta_q, beta_d;
    logic                      row_ready_q, row_ready_d;
    logic                      out_valid_q, out_valid_d;
    logic                      out_x_q, out_x_d;
`ifdef NEURON_SCORE_OUT_EN
    logic signed [ACC_W-1:0]   score_q, score_d;
`endif
    logic signed [DOT_W-1:0]   row_dot;
    logic                      accept;

    row_dot_product #(
        .PIX_W   (PIX_W),
        .WGT_W   (WGT_W),
        .ROW_LEN (ROW_LEN)
    ) u_dot (
        .row_pix (Row_Pixel),
        .row_wgt (Row_Weight),
        .dot     (row_dot)
    );

    assign accept = Row_Valid && row_ready_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        row_cnt_d   = row_cnt_q;
        beta_d      = beta_q;
        out_valid_d = out_valid_q;
        out_x_d     = out_x_q;
`ifdef NEURON_SCORE_OUT_EN
        score_d     = score_q;
`endif
        if (Start) begin
            // Restart from any state; Out_X keeps its last value until the new result.
            state_d     = ACCUM;
            acc_d       = '0;
            row_cnt_d   = '0;
            beta_d      = $signed(Beta);
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (accept) begin
                        acc_d = acc_q + ACC_W'(row_dot);
                        if (row_cnt_q == CNT_W'(NUM_ROWS - 1)) begin
                            state_d = BIAS;
                        end else begin
                            row_cnt_d = row_cnt_q + CNT_W'(1);
                        end
                    end
                end
                BIAS: begin
                    acc_d   = acc_q + ACC_W'(beta_q);
                    state_d = DONE;
                end
                DONE: begin
                    // acc already holds the biased score and is frozen here.
                    out_valid_d = 1'b1;
                    out_x_d     = !acc_q[ACC_W-1] && (acc_q != '0);
`ifdef NEURON_SCORE_OUT_EN
                    score_d     = acc_q;
`endif
                end
                default: begin
                end
            endcase
        end
        row_ready_d = (state_d == ACCUM);
    end

    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            row_cnt_q   <= '0;
            beta_q      <= '0;
            row_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_x_q     <= 1'b0;
`ifdef NEURON_SCORE_OUT_EN
            score_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            row_cnt_q   <= row_cnt_d;
            beta_q      <= beta_d;
            row_ready_q <= row_ready_d;
            out_valid_q <= out_valid_d;
            out_x_q     <= out_x_d;
`ifdef NEURON_SCORE_OUT_EN
            score_q     <= score_d;
`endif
        end
    end

    assign Row_Ready = row_ready_q;
    assign Out_Valid = out_valid_q;
    assign Out_X     = out_x_q;
`ifdef NEURON_SCORE_OUT_EN
    assign Out_Score = score_q;
`endif

endmodule

// File: tb/tb_neuron_row_mac.sv
// Randomized bench for neuron_row_mac against a plain-arithmetic score model (Out_Score checked when NEURON_SCORE_OUT_EN is defined).
module tb_neuron_row_mac;

    localparam int PIX_W    = 10;
    localparam int WGT_W    = 19;
    localparam int ROW_LEN  = 28;
    localparam int NUM_ROWS = 28;
    localparam int ACC_W    = PIX_W + WGT_W + 2 + $clog2(ROW_LEN * NUM_ROWS);

    logic                     clk = 1'b0;
    logic                     GlobalReset;
    logic                     Start;
    logic [WGT_W-1:0]         Beta;
    logic                     Row_Valid;
    logic                     Row_Ready;
    logic [ROW_LEN*PIX_W-1:0] Row_Pixel;
    logic [ROW_LEN*WGT_W-1:0] Row_Weight;
    logic                     Out_Valid;
    logic                     Out_X;
`ifdef NEURON_SCORE_OUT_EN
    logic [ACC_W-1:0]         Out_Score;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [PIX_W-1:0]        pix_m [NUM_ROWS][ROW_LEN];
    logic signed [WGT_W-1:0] wgt_m [NUM_ROWS][ROW_LEN];

    always #5 clk = ~clk;

    neuron_row_mac dut (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .Start       (Start),
        .Beta        (Beta),
        .Row_Valid   (Row_Valid),
        .Row_Ready   (Row_Ready),
        .Row_Pixel   (Row_Pixel),
        .Row_Weight  (Row_Weight),
        .Out_Valid   (Out_Valid),
        .Out_X       (Out_X)
`ifdef NEURON_SCORE_OUT_EN
        ,
        .Out_Score   (Out_Score)
`endif
    );

    // Reference: score = Beta + sum over all rows and pairs of pixel*weight.
    function automatic longint model_score(input int b);
        longint s = longint'(b);
        for (int r = 0; r < NUM_ROWS; r++)
            for (int k = 0; k < ROW_LEN; k++)
                s += longint'(int'(pix_m[r][k])) * longint'(int'(wgt_m[r][k]));
        return s;
    endfunction

    // mode 0 random, 1 all ones, 2 max pixel with most negative weight, 3 keep current
    task automatic fill(input int mode);
        for (int r = 0; r < NUM_ROWS; r++)
            for (int k = 0; k < ROW_LEN; k++) begin
                if (mode == 0) begin
                    pix_m[r][k] = PIX_W'($urandom);
                    wgt_m[r][k] = WGT_W'($urandom);
                end else if (mode == 1) begin
                    pix_m[r][k] = PIX_W'(1);
                    wgt_m[r][k] = WGT_W'(1);
                end else if (mode == 2) begin
                    pix_m[r][k] = PIX_W'(1023);
                    wgt_m[r][k] = WGT_W'(-262144);
                end
            end
    endtask

    task automatic drive_row(input int r);
        for (int k = 0; k < ROW_LEN; k++) begin
            Row_Pixel[k*PIX_W +: PIX_W]  = pix_m[r][k];
            Row_Weight[k*WGT_W +: WGT_W] = wgt_m[r][k];
        end
    endtask

    task automatic start_inf(input int b, input bit beat_with_start);
        @(negedge clk);
        Start     = 1'b1;
        Beta      = WGT_W'(b);
        Row_Valid = beat_with_start;
        if (beat_with_start) begin
            for (int k = 0; k < ROW_LEN; k++) begin
                Row_Pixel[k*PIX_W +: PIX_W]  = PIX_W'($urandom);
                Row_Weight[k*WGT_W +: WGT_W] = WGT_W'($urandom);
            end
        end
        @(negedge clk);
        Start     = 1'b0;
        Row_Valid = 1'b0;
    endtask

    // Offers rows until nrows are accepted; returns at the negedge after the last accept edge.
    task automatic feed(input int nrows, input bit gaps, output bit ok);
        int  r   = 0;
        int  cyc = 0;
        bit  take;
        ok = 1'b1;
        while (r < nrows) begin
            if (cyc >= 400) begin
                ok = 1'b0;
                break;
            end
            Row_Valid = gaps ? ((cyc % 2) == 0) : 1'b1;
            drive_row(r);
            take = Row_Valid && Row_Ready;
            @(negedge clk);
            if (take) r++;
            cyc++;
        end
        Row_Valid = 1'b0;
    endtask

    task automatic test_inference(input int mode, input int b, input bit gaps, input string tag);
        bit     ok;
        longint exp_s;
        fill(mode);
        exp_s = model_score(b);
        start_inf(b, 1'b0);
        feed(NUM_ROWS, gaps, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s_feed_timeout: rows accepted before timeout=no, required=yes", tag);
        end
        n_cmp++;
        if (Out_Valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_valid_early1: Out_Valid=%b required 0", tag, Out_Valid);
        end
        @(negedge clk);
        n_cmp++;
        if (Out_Valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_valid_early2: Out_Valid=%b required 0", tag, Out_Valid);
        end
        @(negedge clk);
        n_cmp++;
        if (Out_Valid !== 1'b1) begin
            n_err++;
            $display("FAIL %s_valid_latency: Out_Valid=%b required 1", tag, Out_Valid);
        end
        n_cmp++;
        if (Out_X !== (exp_s > 0)) begin
            n_err++;
            $display("FAIL %s_out_x: Out_X=%b required %b (score %0d)", tag, Out_X, exp_s > 0, exp_s);
        end
`ifdef NEURON_SCORE_OUT_EN
        n_cmp++;
        if (Out_Score !== ACC_W'(exp_s)) begin
            n_err++;
            $display("FAIL %s_score: Out_Score=%0d required %0d", tag, $signed(Out_Score), exp_s);
        end
`endif
    endtask

    task automatic test_reset();
        GlobalReset = 1'b1;
        Start       = 1'b0;
        Beta        = '0;
        Row_Valid   = 1'b0;
        Row_Pixel   = '0;
        Row_Weight  = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({Row_Ready, Out_Valid, Out_X} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_outputs: Row_Ready,Out_Valid,Out_X=%b required 000", {Row_Ready, Out_Valid, Out_X});
        end
        GlobalReset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (Row_Ready !== 1'b0) begin
            n_err++;
            $display("FAIL idle_ready: Row_Ready=%b required 0", Row_Ready);
        end
    endtask

    task automatic test_boundary();
        test_inference(1, -784, 1'b0, "ones_zero");
        test_inference(1, -783, 1'b0, "ones_plus1");
    endtask

    task automatic test_extreme();
        test_inference(2, 0, 1'b0, "extreme_neg");
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++)
            test_inference(0, int'($urandom_range(0, 524287)) - 262144, i[0], "random");
    endtask

    task automatic test_gaps();
        int b = int'($urandom_range(0, 524287)) - 262144;
        test_inference(0, b, 1'b0, "gapless");
        test_inference(3, b, 1'b1, "gapped");
    endtask

    task automatic test_abort();
        bit     ok;
        longint exp_s;
        int     b2 = int'($urandom_range(0, 524287)) - 262144;
        fill(0);
        start_inf(12345, 1'b0);
        feed(10, 1'b0, ok);
        fill(0);
        exp_s = model_score(b2);
        // The beat offered alongside Start must be ignored.
        start_inf(b2, 1'b1);
        n_cmp++;
        if (Row_Ready !== 1'b1) begin
            n_err++;
            $display("FAIL abort_ready: Row_Ready=%b required 1", Row_Ready);
        end
        feed(NUM_ROWS, 1'b0, ok);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (!ok || Out_Valid !== 1'b1 || Out_X !== (exp_s > 0)) begin
            n_err++;
            $display("FAIL abort_result: ok=%b Out_Valid=%b Out_X=%b required ok=1 valid=1 x=%b", ok, Out_Valid, Out_X, exp_s > 0);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        test_inference(1, 0, 1'b0, "pre_reset");
        #2 GlobalReset = 1'b1;
        #1;
        n_cmp++;
        if (Out_Valid !== 1'b0 || Out_X !== 1'b0) begin
            n_err++;
            $display("FAIL reset_done_async: Out_Valid=%b Out_X=%b required 0 0", Out_Valid, Out_X);
        end
        @(negedge clk);
        GlobalReset = 1'b0;
        fill(0);
        start_inf(7, 1'b0);
        feed(5, 1'b0, ok);
        #2 GlobalReset = 1'b1;
        #1;
        n_cmp++;
        if (Row_Ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_accum_async: Row_Ready=%b required 0", Row_Ready);
        end
        @(negedge clk);
        GlobalReset = 1'b0;
        test_inference(0, int'($urandom_range(0, 524287)) - 262144, 1'b0, "post_reset");
    endtask

    task automatic test_start_in_done();
        bit ok;
        test_inference(1, 0, 1'b0, "done_first");
        fill(2);
        start_inf(0, 1'b0);
        n_cmp++;
        if (Out_Valid !== 1'b0 || Out_X !== 1'b1) begin
            n_err++;
            $display("FAIL restart_clear: Out_Valid=%b Out_X=%b required 0 1", Out_Valid, Out_X);
        end
        feed(NUM_ROWS, 1'b0, ok);
        n_cmp++;
        if (Out_X !== 1'b1) begin
            n_err++;
            $display("FAIL restart_hold_x: Out_X=%b required 1", Out_X);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (Out_Valid !== 1'b1 || Out_X !== 1'b0) begin
            n_err++;
            $display("FAIL restart_result: Out_Valid=%b Out_X=%b required 1 0", Out_Valid, Out_X);
        end
    endtask

    initial begin
        test_reset();
        test_boundary();
        test_extreme();
        test_random();
        test_gaps();
        test_abort();
        test_async_reset();
        test_start_in_done();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
